mod_inverse_bin: RTL and testbench
==================================

MOD_INVERSE_BIN -- requirements
Module: mod_inverse_bin

Interface
REQ-001 SHALL have parameter WIDTH, default 256, operand and modulus bit width (legal range 8..512).
REQ-002 SHALL have port Clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to begin an inversion; sampled only when ready=1.
REQ-005 SHALL have port a  input  WIDTH  operand to invert; captured on accepted start.
REQ-006 SHALL have port p  input  WIDTH  runtime modulus, odd; captured on accepted start.
REQ-007 SHALL have port ready  output  1  high in IDLE only.
REQ-008 SHALL have port done  output  1  one-cycle pulse when result is final.
REQ-009 SHALL have port err  output  1  valid with done: no inverse exists or inputs are illegal.
REQ-010 SHALL have port out  output  WIDTH  a^-1 mod p, valid with done, held until next accepted start.

Function
REQ-011 SHALL implement binary extended Euclid: u=a, v=p, x1=1, x2=0 on accept.
REQ-012 Each RUN cycle SHALL perform exactly one step, in priority order: u even -> u>>=1, x1=half(x1); else v even -> v>>=1, x2=half(x2); else u>=v -> u-=v, x1=(x1-x2) mod p; else v-=u, x2=(x2-x1) mod p.
REQ-013 half(x) SHALL be x>>1 if x even, else (x+p)>>1 computed at WIDTH+1 bits with no overflow loss.
REQ-014 Modular subtraction SHALL add p when the minuend is below the subtrahend; x1, x2 SHALL stay in [0,p-1].
REQ-015 Termination: u==1 -> out=x1; v==1 -> out=x2; u==0 or v==0 -> err=1, out=0.
REQ-016 Input check on accept: a==0, p even, p<3, or a>=p SHALL go directly to DONE with err=1, out=0 (latency 1 cycle).
REQ-017 States SHALL be IDLE -> RUN (accepted start) -> DONE (termination) -> IDLE (unconditional, next cycle).
REQ-018 Latency from accepted start to done SHALL not exceed 2*WIDTH+2 cycles.
REQ-019 start while ready=0 SHALL be ignored; a and p changes during RUN SHALL have no effect.
REQ-020 done SHALL be high only in DONE; start in the DONE cycle SHALL be ignored.

Reset
REQ-021 Reset SHALL force IDLE, ready=1, done=0, err=0, out=0, and clear u, v, x1, x2.
REQ-022 Reset in RUN or DONE SHALL abort the operation with no done pulse; Reset dominates start in the same cycle.

Configuration
REQ-023 Macro MOD_INV_CYCLE_COUNT_EN, when defined, SHALL add output port cycles (16 bits): RUN-cycle count of the last operation, updated with done, reset to 0.
REQ-024 Without MOD_INV_CYCLE_COUNT_EN, the port and counter SHALL not exist; all other behaviour SHALL be identical.

Structure
REQ-025 Package mod_inv_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the default WIDTH constant.
REQ-026 Sub-module mod_half (combinational, parameter WIDTH) SHALL implement half(x) and be instantiated twice (x1, x2).

Verification
REQ-027 WIDTH=256, p=1147, a=5 -> done with out=459, err=0.
REQ-028 p=1147, a=3 then a=2 then a=16 back-to-back -> out=765, 574, 932 respectively, err=0 each.
REQ-029 p=1147, a=31 (shared factor) -> done with err=1, out=0; a=0 -> err=1 one cycle after start.
REQ-030 p=17, a=3 -> out=6; start pulsed during RUN ignored; result and latency <= 514 cycles checked.
REQ-031 Reset asserted mid-RUN for a=5, p=1147 -> no done, ready=1 next cycle; new start a=3 -> out=765.
REQ-032 Random odd p and a<p, 1000 vectors -> (a*out) mod p == 1 when gcd=1, else err=1; with MOD_INV_CYCLE_COUNT_EN, cycles matches the bench count.

Source files
------------

// File: rtl/mod_inv_pkg.sv
// Shared definitions for the binary modular inverter: FSM state encoding
// and the default operand width.
package mod_inv_pkg;

   localparam int DEFAULT_WIDTH = 256;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/mod_half.sv
// Modular halving: returns x/2 mod p for odd p and x in [0,p-1].
// An odd x is made even by adding p first; the sum is kept at WIDTH+1 bits
// so the carry is not lost before the shift.
module mod_half #(
   parameter int WIDTH = 256
) (
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] p,
   output logic [WIDTH-1:0] y
);

   logic [WIDTH:0] sum;

   // Add p for odd x, then drop the (now zero) low bit.
   always_comb begin
      sum = {1'b0, x};
      if (x[0]) begin
         sum = {1'b0, x} + {1'b0, p};
      end
      y = sum[WIDTH:1];
   end

endmodule

// File: rtl/mod_inverse_bin.sv
// Modular inverse a^-1 mod p by the binary extended Euclidean algorithm,
// one reduction step per clock. The runtime modulus p must be odd.
// Optional feature: define MOD_INV_CYCLE_COUNT_EN to add the 16-bit
// 'cycles' output reporting the RUN-cycle count of the last operation.
module mod_inverse_bin
   import mod_inv_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] p,
   output logic             ready,
   output logic             done,
   output logic             err,
   output logic [WIDTH-1:0] out
`ifdef MOD_INV_CYCLE_COUNT_EN
   ,
   output logic [15:0]      cycles
`endif
);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] u_q, u_d;
   logic [WIDTH-1:0] v_q, v_d;
   logic [WIDTH-1:0] x1_q, x1_d;
   logic [WIDTH-1:0] x2_q, x2_d;
   logic [WIDTH-1:0] p_q, p_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic             err_q, err_d;

   logic [WIDTH-1:0] x1_half;
   logic [WIDTH-1:0] x2_half;
   logic             illegal_in;

   // (m - s) mod md for m, s in [0,md-1]; wraps at WIDTH+1 bits, then adds md back.
   function automatic logic [WIDTH-1:0] mod_sub(input logic [WIDTH-1:0] m,
                                                input logic [WIDTH-1:0] s,
                                                input logic [WIDTH-1:0] md);
      logic [WIDTH:0] t;
      t = {1'b0, m} - {1'b0, s};
      if (m < s) begin
         t = t + {1'b0, md};
      end
      return t[WIDTH-1:0];
   endfunction

   mod_half #(.WIDTH(WIDTH)) u_half_x1 (
      .x (x1_q),
      .p (p_q),
      .y (x1_half)
   );

   mod_half #(.WIDTH(WIDTH)) u_half_x2 (
      .x (x2_q),
      .p (p_q),
      .y (x2_half)
   );

   assign illegal_in = (a == '0) || !p[0] || (p < WIDTH'(3)) || (a >= p);

   // Next-state logic: operand capture, one Euclid step per RUN cycle, termination.
   always_comb begin
      state_d = state_q;
      u_d     = u_q;
      v_d     = v_q;
      x1_d    = x1_q;
      x2_d    = x2_q;
      p_d     = p_q;
      out_d   = out_q;
      err_d   = err_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               if (illegal_in) begin
                  out_d   = '0;
                  err_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  u_d     = a;
                  v_d     = p;
                  x1_d    = WIDTH'(1);
                  x2_d    = '0;
                  p_d     = p;
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            if (u_q == WIDTH'(1)) begin
               out_d   = x1_q;
               err_d   = 1'b0;
               state_d = DONE;
            end else if (v_q == WIDTH'(1)) begin
               out_d   = x2_q;
               err_d   = 1'b0;
               state_d = DONE;
            end else if ((u_q == '0) || (v_q == '0)) begin
               // gcd(a,p) > 1: one operand collapsed to zero without reaching 1.
               out_d   = '0;
               err_d   = 1'b1;
               state_d = DONE;
            end else if (!u_q[0]) begin
               u_d  = u_q >> 1;
               x1_d = x1_half;
            end else if (!v_q[0]) begin
               v_d  = v_q >> 1;
               x2_d = x2_half;
            end else if (u_q >= v_q) begin
               u_d  = u_q - v_q;
               x1_d = mod_sub(x1_q, x2_q, p_q);
            end else begin
               v_d  = v_q - u_q;
               x2_d = mod_sub(x2_q, x1_q, p_q);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= IDLE;
         u_q     <= '0;
         v_q     <= '0;
         x1_q    <= '0;
         x2_q    <= '0;
         p_q     <= '0;
         out_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         u_q     <= u_d;
         v_q     <= v_d;
         x1_q    <= x1_d;
         x2_q    <= x2_d;
         p_q     <= p_d;
         out_q   <= out_d;
         err_q   <= err_d;
      end
   end

   assign ready = (state_q == IDLE);
   assign done  = (state_q == DONE);
   assign err   = err_q;
   assign out   = out_q;

`ifdef MOD_INV_CYCLE_COUNT_EN
   logic [15:0] run_cnt_q, run_cnt_d;
   logic [15:0] cycles_q, cycles_d;

   // Count RUN cycles; publish the total when the operation ends (0 for rejected inputs).
   always_comb begin
      run_cnt_d = run_cnt_q;
      cycles_d  = cycles_q;
      if (state_q == IDLE && start) begin
         run_cnt_d = '0;
         if (illegal_in) begin
            cycles_d = '0;
         end
      end else if (state_q == RUN) begin
         run_cnt_d = run_cnt_q + 16'd1;
         if (state_d == DONE) begin
            cycles_d = run_cnt_q + 16'd1;
         end
      end
   end

   // Counter registers with synchronous reset.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         run_cnt_q <= '0;
         cycles_q  <= '0;
      end else begin
         run_cnt_q <= run_cnt_d;
         cycles_q  <= cycles_d;
      end
   end

   assign cycles = cycles_q;
`endif

endmodule

// File: tb/tb_mod_inverse_bin.sv
// Scoreboard bench for mod_inverse_bin: the driver pushes expected results
// when a start is accepted, the monitor pops and compares on every done.
module tb_mod_inverse_bin;

   localparam int W       = 256;
   localparam int LAT_MAX = 2 * W + 2;

   logic         Clk = 1'b0;
   logic         Reset;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] p;
   logic         ready;
   logic         done;
   logic         err;
   logic [W-1:0] out;
`ifdef MOD_INV_CYCLE_COUNT_EN
   logic [15:0]  cycles;
`endif

   mod_inverse_bin #(.WIDTH(W)) dut (
      .Clk    (Clk),
      .Reset  (Reset),
      .start  (start),
      .a      (a),
      .p      (p),
      .ready  (ready),
      .done   (done),
      .err    (err),
      .out    (out)
`ifdef MOD_INV_CYCLE_COUNT_EN
      ,
      .cycles (cycles)
`endif
   );

   always #5 Clk = ~Clk;

   int cyc = 0;
   always @(posedge Clk) cyc <= cyc + 1;

   int n_total = 0;
   int n_pass  = 0;

   typedef struct {
      int           id;
      logic [W-1:0] exp_out;
      bit           exp_err;
      int           exp_lat;   // 0 = only the upper bound is checked
      int           acc_cyc;
   } exp_t;

   exp_t sb[$];

   task automatic check_val(input string name, input int id,
                            input logic [W-1:0] act, input logic [W-1:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s id=%0d actual=%0h required=%0h", name, id, act, req);
   endtask

   task automatic check_le(input string name, input int id, input int act, input int lim);
      n_total++;
      if (act <= lim) n_pass++;
      else $display("FAIL %s id=%0d actual=%0d required<=%0d", name, id, act, lim);
   endtask

   // Reference inverse by division-based extended Euclid on small operands.
   function automatic void model(input longint ma, input longint mp,
                                 output longint inv, output bit e);
      longint r0, r1, t0, t1, q, tmp;
      inv = 0;
      e   = 1'b1;
      if (ma == 0 || (mp % 2) == 0 || mp < 3 || ma >= mp) return;
      r0 = mp; r1 = ma; t0 = 0; t1 = 1;
      while (r1 != 0) begin
         q   = r0 / r1;
         tmp = r0 - q * r1; r0 = r1; r1 = tmp;
         tmp = t0 - q * t1; t0 = t1; t1 = tmp;
      end
      if (r0 == 1) begin
         if (t0 < 0) t0 = t0 + mp;
         inv = t0;
         e   = 1'b0;
      end
   endfunction

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge Clk) begin
      exp_t e;
      int   lat;
      if (done === 1'b1) begin
         if (sb.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_done actual=done required=no_done cyc=%0d", cyc);
         end else begin
            e   = sb.pop_front();
            lat = cyc - e.acc_cyc + 1;
            $display("txn id=%0d out=%0h err=%0b latency=%0d", e.id, out, err, lat);
            check_val("out", e.id, out, e.exp_out);
            check_val("err", e.id, W'(err), W'(e.exp_err));
            if (e.exp_lat > 0) check_val("latency", e.id, W'(lat), W'(e.exp_lat));
            check_le("latency_bound", e.id, lat, LAT_MAX);
`ifdef MOD_INV_CYCLE_COUNT_EN
            check_val("cycles", e.id, W'(cycles), W'(lat - 1));
`endif
         end
      end
   end

   task automatic wait_ready(input int id, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge Clk);
         if (ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         n_total++;
         $display("FAIL ready_timeout id=%0d actual=ready_low required=ready_high", id);
      end
   endtask

   // Drive one start at a negedge with ready high; it is accepted on the next posedge.
   task automatic pulse_start(input int id, input logic [W-1:0] ta, input logic [W-1:0] tp,
                              output bit ok);
      wait_ready(id, ok);
      if (ok) begin
         start = 1'b1;
         a     = ta;
         p     = tp;
         @(posedge Clk);
         #1;
         start = 1'b0;
      end
   endtask

   task automatic issue(input int id, input logic [W-1:0] ta, input logic [W-1:0] tp,
                        input logic [W-1:0] eo, input bit ee, input int el);
      bit   ok;
      exp_t e;
      pulse_start(id, ta, tp, ok);
      if (ok) begin
         e.id = id; e.exp_out = eo; e.exp_err = ee; e.exp_lat = el; e.acc_cyc = cyc;
         sb.push_back(e);
      end
   endtask

   initial begin
      bit     ok;
      longint ra, rp, inv;
      bit     re;

      Reset = 1'b1; start = 1'b0; a = '0; p = '0;
      repeat (3) @(negedge Clk);
      check_val("rst_ready", 0, W'(ready), W'(1));
      check_val("rst_done",  0, W'(done),  W'(0));
      check_val("rst_err",   0, W'(err),   W'(0));
      check_val("rst_out",   0, out,       W'(0));
      Reset = 1'b0;

      issue(1, W'(5),  W'(1147), W'(459), 1'b0, 0);
      issue(2, W'(3),  W'(1147), W'(765), 1'b0, 0);
      issue(3, W'(2),  W'(1147), W'(574), 1'b0, 0);
      issue(4, W'(16), W'(1147), W'(932), 1'b0, 0);
      issue(5, W'(31), W'(1147), W'(0),   1'b1, 0);
      issue(6, W'(0),  W'(1147), W'(0),   1'b1, 1);
      issue(7, W'(5),  W'(1146), W'(0),   1'b1, 1);
      issue(8, W'(1),  W'(1),    W'(0),   1'b1, 1);
      issue(9, W'(1147), W'(1147), W'(0), 1'b1, 1);
      issue(10, W'(1), W'(1147), W'(1),   1'b0, 0);
      issue(11, W'(1146), W'(1147), W'(1146), 1'b0, 0);

      // Start and operand changes while busy must be ignored.
      issue(12, W'(3), W'(17), W'(6), 1'b0, 0);
      @(negedge Clk);
      check_val("busy_ready", 12, W'(ready), W'(0));
      start = 1'b1; a = W'(7); p = W'(1147);
      @(posedge Clk);
      #1;
      start = 1'b0;

      // Reset in the middle of a run aborts it without a done pulse.
      pulse_start(13, W'(5), W'(1147), ok);
      repeat (3) @(posedge Clk);
      #1;
      Reset = 1'b1;
      @(posedge Clk);
      #1;
      Reset = 1'b0;
      @(negedge Clk);
      check_val("abort_ready", 13, W'(ready), W'(1));
      check_val("abort_done",  13, W'(done),  W'(0));
      check_val("abort_out",   13, out,       W'(0));
      issue(14, W'(3), W'(1147), W'(765), 1'b0, 0);

      for (int i = 0; i < 1000; i++) begin
         rp = longint'($urandom & 32'h000F_FFFF) | 1;
         if (rp < 3) rp = 3;
         ra = longint'($urandom_range(0, 32'(rp - 1)));
         model(ra, rp, inv, re);
         issue(100 + i, W'(ra), W'(rp), W'(inv), re, (ra == 0) ? 1 : 0);
      end

      for (int i = 0; i < 3000 && sb.size() != 0; i++) @(negedge Clk);
      if (sb.size() != 0) begin
         n_total++;
         $display("FAIL drain_timeout actual=%0d_pending required=0_pending", sb.size());
      end
      repeat (2) @(negedge Clk);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
